// File: rtl/decode_stage_reg.sv
// decode_stage_reg: MIPS decode stage with integrated register file,
// write-through bypass, branch comparator with operand forwarding,
// branch target adder and the ID/EX pipeline register.
// Stalled or flushed edges load a bubble and bump a saturating counter.
module decode_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr_d,
  input  logic [DATA_W-1:0] pc_plus_4_d,
  input  logic              valid_d,
  input  logic              stall_d,
  input  logic              flush_e,
  input  logic              branch_ne_d,
  input  logic              reg_we_w,
  input  logic [4:0]        reg_write_addr_w,
  input  logic [DATA_W-1:0] reg_write_data_w,
  input  logic [DATA_W-1:0] alu_result_m,
  input  logic [1:0]        forward_a_d,
  input  logic [1:0]        forward_b_d,
  output logic              branch_cond_d,
  output logic [DATA_W-1:0] pc_branch_d,
  output logic [DATA_W-1:0] reg_data_1_e,
  output logic [DATA_W-1:0] reg_data_2_e,
  output logic [4:0]        rs_e,
  output logic [4:0]        rt_e,
  output logic [4:0]        rd_e,
  output logic [DATA_W-1:0] imm_e,
  output logic [DATA_W-1:0] shamt_e,
  output logic [DATA_W-1:0] pc_plus_4_e,
  output logic              valid_e,
  output logic [CNT_W-1:0]  bubble_count
);

  // Register-file read with write-through: r0 is hard zero, a same-cycle
  // writeback to the addressed register wins over the stored value.
  function automatic logic [DATA_W-1:0] rf_read(
    input logic [4:0]        addr,
    input logic              we,
    input logic [4:0]        waddr,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] val;
    val = {DATA_W{1'b0}};
    if (addr == 5'd0) begin
      val = {DATA_W{1'b0}};
    end else if (we && (waddr == addr)) begin
      val = wdata;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  // Branch operand source select; code 3 falls back to the register read.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] rf_val,
    input logic [DATA_W-1:0] mem_val,
    input logic [DATA_W-1:0] wb_val
  );
    logic [DATA_W-1:0] val;
    val = rf_val;
    case (sel)
      2'd0:    val = rf_val;
      2'd1:    val = mem_val;
      2'd2:    val = wb_val;
      default: val = rf_val;
    endcase
    return val;
  endfunction

  // Register file and ID/EX state
  logic [DATA_W-1:0] r_regs [0:31];
  logic [DATA_W-1:0] r_reg_data_1;
  logic [DATA_W-1:0] r_reg_data_2;
  logic [4:0]        r_rs;
  logic [4:0]        r_rt;
  logic [4:0]        r_rd;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_shamt;
  logic [DATA_W-1:0] r_pc_plus_4;
  logic              r_valid;
  logic [CNT_W-1:0]  r_bubble_count;

  // Decoded fields and datapath wires
  logic [4:0]        w_rs;
  logic [4:0]        w_rt;
  logic [4:0]        w_rd;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_shamt;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_op_b;
  logic              w_bubble;
  logic              w_unused_opcode;

  assign w_rs    = instr_d[25:21];
  assign w_rt    = instr_d[20:16];
  assign w_rd    = instr_d[15:11];
  assign w_imm   = {{(DATA_W-16){instr_d[15]}}, instr_d[15:0]};
  assign w_shamt = {{(DATA_W-5){1'b0}}, instr_d[10:6]};

  // The opcode is decoded by the control unit, not here.
  assign w_unused_opcode = ^instr_d[31:26];

  // A stall or flush on this edge turns the ID/EX load into a bubble.
  assign w_bubble = flush_e | stall_d;

  // Combinational register reads with bypass and forwarded branch operands.
  always_comb begin
    w_rd1  = rf_read(w_rs, reg_we_w, reg_write_addr_w, reg_write_data_w, r_regs[w_rs]);
    w_rd2  = rf_read(w_rt, reg_we_w, reg_write_addr_w, reg_write_data_w, r_regs[w_rt]);
    w_op_a = fwd_sel(forward_a_d, w_rd1, alu_result_m, reg_write_data_w);
    w_op_b = fwd_sel(forward_b_d, w_rd2, alu_result_m, reg_write_data_w);
  end

  // Branch comparator (equal / not-equal) and target adder.
  always_comb begin
    branch_cond_d = (w_op_a == w_op_b) ^ branch_ne_d;
    pc_branch_d   = pc_plus_4_d + {w_imm[DATA_W-3:0], 2'b00};
  end

  // Register array: cleared on reset, writes to r0 dropped. A write is
  // never suppressed by a stall or flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= {DATA_W{1'b0}};
      end
    end else if (reg_we_w && (reg_write_addr_w != 5'd0)) begin
      r_regs[reg_write_addr_w] <= reg_write_data_w;
    end
  end

  // ID/EX register: flush and stall both load an all-zero bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reg_data_1 <= {DATA_W{1'b0}};
      r_reg_data_2 <= {DATA_W{1'b0}};
      r_rs         <= 5'd0;
      r_rt         <= 5'd0;
      r_rd         <= 5'd0;
      r_imm        <= {DATA_W{1'b0}};
      r_shamt      <= {DATA_W{1'b0}};
      r_pc_plus_4  <= {DATA_W{1'b0}};
      r_valid      <= 1'b0;
    end else if (w_bubble) begin
      r_reg_data_1 <= {DATA_W{1'b0}};
      r_reg_data_2 <= {DATA_W{1'b0}};
      r_rs         <= 5'd0;
      r_rt         <= 5'd0;
      r_rd         <= 5'd0;
      r_imm        <= {DATA_W{1'b0}};
      r_shamt      <= {DATA_W{1'b0}};
      r_pc_plus_4  <= {DATA_W{1'b0}};
      r_valid      <= 1'b0;
    end else begin
      r_reg_data_1 <= w_rd1;
      r_reg_data_2 <= w_rd2;
      r_rs         <= w_rs;
      r_rt         <= w_rt;
      r_rd         <= w_rd;
      r_imm        <= w_imm;
      r_shamt      <= w_shamt;
      r_pc_plus_4  <= pc_plus_4_d;
      r_valid      <= valid_d;
    end
  end

  // Saturating bubble counter: one count per bubble edge, sticks at max.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bubble_count <= {CNT_W{1'b0}};
    end else if (w_bubble && (r_bubble_count != {CNT_W{1'b1}})) begin
      r_bubble_count <= r_bubble_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_bubble_count <= r_bubble_count;
    end
  end

  assign reg_data_1_e = r_reg_data_1;
  assign reg_data_2_e = r_reg_data_2;
  assign rs_e         = r_rs;
  assign rt_e         = r_rt;
  assign rd_e         = r_rd;
  assign imm_e        = r_imm;
  assign shamt_e      = r_shamt;
  assign pc_plus_4_e  = r_pc_plus_4;
  assign valid_e      = r_valid;
  assign bubble_count = r_bubble_count;

endmodule

// File: tb/tb_decode_stage_reg.sv
// Directed self-checking bench for decode_stage_reg. A second instance
// with a 2-bit bubble counter exercises saturation.
module tb_decode_stage_reg;

  logic        clk;
  logic        reset;
  logic [31:0] instr_d;
  logic [31:0] pc_plus_4_d;
  logic        valid_d;
  logic        stall_d;
  logic        flush_e;
  logic        branch_ne_d;
  logic        reg_we_w;
  logic [4:0]  reg_write_addr_w;
  logic [31:0] reg_write_data_w;
  logic [31:0] alu_result_m;
  logic [1:0]  forward_a_d;
  logic [1:0]  forward_b_d;

  logic        branch_cond_d;
  logic [31:0] pc_branch_d;
  logic [31:0] reg_data_1_e, reg_data_2_e;
  logic [4:0]  rs_e, rt_e, rd_e;
  logic [31:0] imm_e, shamt_e, pc_plus_4_e;
  logic        valid_e;
  logic [15:0] bubble_count;

  logic        d2_branch_cond_d;
  logic [31:0] d2_pc_branch_d;
  logic [31:0] d2_reg_data_1_e, d2_reg_data_2_e;
  logic [4:0]  d2_rs_e, d2_rt_e, d2_rd_e;
  logic [31:0] d2_imm_e, d2_shamt_e, d2_pc_plus_4_e;
  logic        d2_valid_e;
  logic [1:0]  d2_bubble_count;

  int n_tests = 0;
  int n_fail  = 0;

  decode_stage_reg #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .instr_d(instr_d), .pc_plus_4_d(pc_plus_4_d),
    .valid_d(valid_d), .stall_d(stall_d), .flush_e(flush_e),
    .branch_ne_d(branch_ne_d), .reg_we_w(reg_we_w),
    .reg_write_addr_w(reg_write_addr_w), .reg_write_data_w(reg_write_data_w),
    .alu_result_m(alu_result_m), .forward_a_d(forward_a_d),
    .forward_b_d(forward_b_d), .branch_cond_d(branch_cond_d),
    .pc_branch_d(pc_branch_d), .reg_data_1_e(reg_data_1_e),
    .reg_data_2_e(reg_data_2_e), .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e),
    .imm_e(imm_e), .shamt_e(shamt_e), .pc_plus_4_e(pc_plus_4_e),
    .valid_e(valid_e), .bubble_count(bubble_count)
  );

  decode_stage_reg #(.DATA_W(32), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .instr_d(instr_d), .pc_plus_4_d(pc_plus_4_d),
    .valid_d(valid_d), .stall_d(stall_d), .flush_e(flush_e),
    .branch_ne_d(branch_ne_d), .reg_we_w(reg_we_w),
    .reg_write_addr_w(reg_write_addr_w), .reg_write_data_w(reg_write_data_w),
    .alu_result_m(alu_result_m), .forward_a_d(forward_a_d),
    .forward_b_d(forward_b_d), .branch_cond_d(d2_branch_cond_d),
    .pc_branch_d(d2_pc_branch_d), .reg_data_1_e(d2_reg_data_1_e),
    .reg_data_2_e(d2_reg_data_2_e), .rs_e(d2_rs_e), .rt_e(d2_rt_e),
    .rd_e(d2_rd_e), .imm_e(d2_imm_e), .shamt_e(d2_shamt_e),
    .pc_plus_4_e(d2_pc_plus_4_e), .valid_e(d2_valid_e),
    .bubble_count(d2_bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_i(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [15:0] imm);
    return {6'b000100, rs, rt, imm};
  endfunction

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    reg_we_w = 1'b1; reg_write_addr_w = addr; reg_write_data_w = data;
    step();
    reg_we_w = 1'b0;
  endtask

  logic [1:0] sat_exp [5];

  initial begin
    reset = 1'b1; instr_d = 32'd0; pc_plus_4_d = 32'd0; valid_d = 1'b0;
    stall_d = 1'b0; flush_e = 1'b0; branch_ne_d = 1'b0; reg_we_w = 1'b0;
    reg_write_addr_w = 5'd0; reg_write_data_w = 32'd0; alu_result_m = 32'd0;
    forward_a_d = 2'd0; forward_b_d = 2'd0;
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

    // Reset state
    #1;
    check_eq("rst_valid_e", valid_e, 1'b0);
    check_eq("rst_rd_e", rd_e, 5'd0);
    check_eq("rst_count", bubble_count, 16'd0);
    #12 reset = 1'b0;

    // Fill ID/EX with a valid entry (rd=7, rs=5) then reset mid-cycle
    wr(5'd5, 32'h55);
    instr_d = mk_i(5'd5, 5'd0, 16'h3800); valid_d = 1'b1;
    #1 check_eq("r5_ne_zero", branch_cond_d, 1'b0);
    step();
    check_eq("pre_rst_valid", valid_e, 1'b1);
    check_eq("pre_rst_rd", rd_e, 5'd7);
    check_eq("pre_rst_rd1", reg_data_1_e, 32'h55);
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_valid", valid_e, 1'b0);
    check_eq("async_rst_rd", rd_e, 5'd0);
    check_eq("async_rst_rd1", reg_data_1_e, 32'd0);
    check_eq("async_rst_count", bubble_count, 16'd0);
    check_eq("async_rst_r5_zero", branch_cond_d, 1'b1);
    #3 reset = 1'b0;
    step();

    // Write-through bypass
    reg_we_w = 1'b1; reg_write_addr_w = 5'd8; reg_write_data_w = 32'hDEADBEEF;
    instr_d = mk_i(5'd8, 5'd0, 16'h0000); forward_b_d = 2'd2;
    #1 check_eq("bypass_op_a", branch_cond_d, 1'b1);
    step();
    check_eq("bypass_rd1_e", reg_data_1_e, 32'hDEADBEEF);
    reg_we_w = 1'b0; forward_b_d = 2'd0;
    step();
    check_eq("array_rd1_e", reg_data_1_e, 32'hDEADBEEF);
    reg_we_w = 1'b1; reg_write_addr_w = 5'd0; reg_write_data_w = 32'h1234;
    instr_d = mk_i(5'd0, 5'd0, 16'h0000); forward_b_d = 2'd2;
    #1 check_eq("r0_bypass_blocked", branch_cond_d, 1'b0);
    step();
    check_eq("r0_rd1_e", reg_data_1_e, 32'd0);
    reg_we_w = 1'b0; forward_b_d = 2'd0;
    step();
    check_eq("r0_after_write", reg_data_1_e, 32'd0);

    // Forwarding and branch mode
    wr(5'd1, 32'd5);
    wr(5'd2, 32'd9);
    instr_d = mk_i(5'd1, 5'd2, 16'h0000); alu_result_m = 32'd9;
    forward_a_d = 2'd1; forward_b_d = 2'd0; branch_ne_d = 1'b0;
    #1 check_eq("fwd_mem_eq", branch_cond_d, 1'b1);
    branch_ne_d = 1'b1;
    #1 check_eq("fwd_mem_ne", branch_cond_d, 1'b0);
    branch_ne_d = 1'b0; forward_a_d = 2'd0;
    #1 check_eq("no_fwd_eq", branch_cond_d, 1'b0);
    forward_a_d = 2'd1; forward_b_d = 2'd3;
    #1 check_eq("fwd_b3_regfile", branch_cond_d, 1'b1);
    forward_a_d = 2'd0;
    #1 check_eq("fwd_b3_noeq", branch_cond_d, 1'b0);
    forward_a_d = 2'd2; forward_b_d = 2'd0; reg_write_data_w = 32'd9;
    #1 check_eq("fwd_wb_eq", branch_cond_d, 1'b1);
    step();
    check_eq("unfwd_rd1_e", reg_data_1_e, 32'd5);
    check_eq("unfwd_rd2_e", reg_data_2_e, 32'd9);
    forward_a_d = 2'd0; alu_result_m = 32'd0;

    // Branch target
    pc_plus_4_d = 32'h1000; instr_d = mk_i(5'd0, 5'd0, 16'hFFFF);
    #1 check_eq("target_neg", pc_branch_d, 32'h0FFC);
    instr_d = mk_i(5'd0, 5'd0, 16'h0004);
    #1 check_eq("target_pos", pc_branch_d, 32'h1010);
    instr_d = mk_i(5'd0, 5'd0, 16'h07C0);
    #1 check_eq("target_big", pc_branch_d, 32'h2F00);
    step();
    check_eq("imm_e", imm_e, 32'h000007C0);
    check_eq("shamt_e", shamt_e, 32'd31);
    check_eq("pc4_e", pc_plus_4_e, 32'h1000);

    // Stall / flush priority and bubble contents
    instr_d = mk_i(5'd3, 5'd4, 16'h2845); valid_d = 1'b1; stall_d = 1'b1;
    step();
    check_eq("stall1_valid", valid_e, 1'b0);
    check_eq("stall1_rd", rd_e, 5'd0);
    check_eq("stall1_rs", rs_e, 5'd0);
    check_eq("stall1_imm", imm_e, 32'd0);
    check_eq("stall1_pc4", pc_plus_4_e, 32'd0);
    check_eq("stall1_count", bubble_count, 16'd1);
    step();
    check_eq("stall2_count", bubble_count, 16'd2);
    flush_e = 1'b1;
    step();
    check_eq("both_valid", valid_e, 1'b0);
    check_eq("both_count", bubble_count, 16'd3);
    stall_d = 1'b0; flush_e = 1'b0;
    step();
    check_eq("normal_valid", valid_e, 1'b1);
    check_eq("normal_rd", rd_e, 5'd5);
    check_eq("normal_rs", rs_e, 5'd3);
    check_eq("normal_rt", rt_e, 5'd4);
    check_eq("normal_imm", imm_e, 32'h2845);
    check_eq("normal_count", bubble_count, 16'd3);
    flush_e = 1'b1;
    step();
    check_eq("flush_valid", valid_e, 1'b0);
    check_eq("flush_count", bubble_count, 16'd4);
    flush_e = 1'b0;

    // Writeback during a stall still reaches the array
    stall_d = 1'b1; reg_we_w = 1'b1; reg_write_addr_w = 5'd10;
    reg_write_data_w = 32'hA5; instr_d = mk_i(5'd10, 5'd0, 16'h0000);
    step();
    check_eq("stall_wr_rd1", reg_data_1_e, 32'd0);
    check_eq("stall_wr_count", bubble_count, 16'd5);
    reg_we_w = 1'b0; stall_d = 1'b0; reg_write_data_w = 32'd0;
    step();
    check_eq("stall_wr_kept", reg_data_1_e, 32'hA5);

    // Normal edge with an empty decode slot does not count
    valid_d = 1'b0;
    step();
    check_eq("empty_valid", valid_e, 1'b0);
    check_eq("empty_count", bubble_count, 16'd5);

    // Saturation on the 2-bit counter
    #2 reset = 1'b1;
    #1;
    check_eq("sat_rst_count", d2_bubble_count, 2'd0);
    check_eq("main_rst_count", bubble_count, 16'd0);
    #3 reset = 1'b0;
    stall_d = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq($sformatf("sat_count_%0d", i), d2_bubble_count, sat_exp[i]);
      check_eq($sformatf("main_count_%0d", i), bubble_count, 16'(i + 1));
    end
    stall_d = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
